dmem_bridge: RTL and testbench
==============================

# dmem_bridge

Data-memory bridge that sits directly downstream of the pipelined CPU's memory stage. It takes the single-cycle word request (`mem_addr`, `mem_write_data`, `mem_wr`, `mem_rd`) and converts it into a req/ack transaction on a variable-latency external memory bus. It returns `mem_read_data` and drives a `stall` that freezes the pipeline registers and PC while a transaction is outstanding. A one-entry write-through read cache lets repeated loads to the same word complete without stalling.

## Interface
- `TIMEOUT`, default 255: cycles in REQ without `bus_ack`/`bus_err` before abort; 8-bit counter, range 1..255.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `mem_addr` input 32: word address from the EX/MEM register.
- `mem_write_data` input 32: store data, already size-filtered.
- `mem_wr` input 1: store request.
- `mem_rd` input 1: load request.
- `mem_read_data` output 32: load data to the MEM/WB register.
- `stall` output 1: freeze the pipeline this cycle; combinational.
- `bus_req` output 1: registered; transaction valid.
- `bus_we` output 1: registered; 1 = write.
- `bus_addr` output 32: registered.
- `bus_wdata` output 32: registered.
- `bus_ack` input 1: transaction complete.
- `bus_rdata` input 32: read data, valid with `bus_ack`.
- `bus_err` input 1: transaction failed; terminates like `bus_ack`.
- `err_flag` output 1: sticky error indicator; cleared only by reset.

## Operation
- Request decode:
  - `mem_wr` = 1 → write, regardless of `mem_rd`.
  - `mem_rd` = 1 and `mem_wr` = 0 → read.
  - Neither → no request.
- Cache: one entry holding `valid`, `tag[31:0]` and `data[31:0]`.
  - Hit = `valid` and `tag == mem_addr`.
- State machine:
  - **IDLE**
    - Read hit: `mem_read_data` = `cache.data`; `stall` = 0; stay in IDLE.
    - Read miss or any write: `stall` = 1; latch `bus_addr`, `bus_wdata`, `bus_we`; set `bus_req` = 1; clear the timeout counter; go to REQ.
    - No request: `stall` = 0; stay in IDLE.
  - **REQ**
    - `bus_req` = 1; `stall` = 1; counter increments each cycle.
    - On `bus_ack`, read:
      - capture `bus_rdata` into `rdata_q`;
      - load the cache with `valid` = 1, `tag` = `bus_addr`, `data` = `bus_rdata`.
    - On `bus_ack`, write:
      - if the cache is valid and `tag == bus_addr`, update `cache.data` with `bus_wdata` (write-through);
      - on a write miss, do not allocate.
    - On `bus_err`: set `rdata_q` = 0; set `err_flag` = 1; leave the cache unchanged. If `bus_ack` and `bus_err` are both high, `bus_err` wins.
    - On counter reaching `TIMEOUT`: set `rdata_q` = 32'hDEADBEEF; set `err_flag` = 1; leave the cache unchanged.
    - Any of the three terminations: drop `bus_req` (registered) and go to DONE.
  - **DONE**
    - `stall` = 0; `mem_read_data` = `rdata_q`.
    - The pipeline advances on this edge.
    - The request still visible on the inputs is not re-issued.
    - Go to IDLE unconditionally.
- `mem_read_data` outside a hit or DONE holds `rdata_q`.
- `bus_*` inputs are ignored outside REQ, so a late ack after a timeout or reset is harmless.
- Reset values:
  - state = IDLE;
  - `bus_req`, `bus_we` = 0; `bus_addr`, `bus_wdata` = 0;
  - `rdata_q` = 0, so `mem_read_data` = 0;
  - cache `valid` = 0; `err_flag` = 0; counter = 0.
  - `stall` follows the inputs combinationally (IDLE rules).
- Reset mid-REQ: `bus_req` falls asynchronously, the transaction is abandoned, and the cache stays invalid.

## Timing
- Read hit: 0 stall cycles; data combinational in the same cycle.
- Miss or write with `bus_ack` N cycles after `bus_req` rises (N ≥ 0, i.e. ack in the first REQ cycle):
  - `stall` high for N+2 cycles: the IDLE cycle plus the REQ cycles;
  - DONE cycle follows with `stall` = 0 and data valid.
- `bus_req` rises on the edge after the request is seen, and falls on the edge after ack/err/timeout.
- Back-to-back requests: the next request is sampled in the IDLE cycle after DONE. Minimum issue rate on misses is one per 3 cycles.
- Timeout: exactly `TIMEOUT` REQ cycles, then DONE.
- `stall` must not depend on `bus_ack` combinationally: it is a function of state, `mem_rd`, `mem_wr` and hit only.

## Test plan
- Read miss at `mem_addr` = 0x100, `bus_ack` after 3 REQ cycles with `bus_rdata` = 0xCAFE0001.
  - Expect `stall` high 5 cycles, `bus_req` high 4 cycles.
  - DONE: `mem_read_data` = 0xCAFE0001.
- Read hit: repeat the read of 0x100 after IDLE.
  - Expect `stall` = 0, `mem_read_data` = 0xCAFE0001, `bus_req` stays 0.
- Write 0x12345678 to 0x100 with immediate ack, then read 0x100.
  - Write: `bus_we` = 1 and `bus_wdata` = 0x12345678 on the bus.
  - Following read hits with 0x12345678 and no bus activity.
- Write to 0x200 (miss) then read 0x200.
  - Read misses and goes to the bus, confirming no write-allocate.
- `bus_err` on a read of 0x300.
  - `mem_read_data` = 0 in DONE; `err_flag` = 1 and stays set.
  - Subsequent read of 0x300 still misses.
- No ack with `TIMEOUT` = 4.
  - `stall` high 5 cycles, then DONE with 0xDEADBEEF and `err_flag` = 1.
  - A second variant asserts `reset` during REQ: `bus_req` drops immediately, and a late `bus_ack` afterwards causes no state change.

Source files
------------

// File: rtl/dmem_bridge.sv
// Data-memory bridge between the CPU memory stage and a req/ack external bus.
// Has a one-entry write-through read cache so repeated loads of one word skip the bus.
module dmem_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    input  logic        mem_wr,
    input  logic        mem_rd,
    output logic [31:0] mem_read_data,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err,
    output logic        err_flag
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] rdata_q;
    logic        cache_valid;
    logic [31:0] cache_tag;
    logic [31:0] cache_data;
    logic [7:0]  cnt;

    logic hit;
    logic rd_only;
    logic issue;
    logic expired;

    assign hit     = cache_valid && (cache_tag == mem_addr);
    assign rd_only = mem_rd && !mem_wr;
    assign issue   = mem_wr || (rd_only && !hit);
    // cnt holds the number of REQ cycles already completed
    assign expired = (cnt == 8'(TIMEOUT - 1));

    // stall depends only on state, request and hit; never on the bus response
    always_comb begin
        state_next    = state;
        stall         = 1'b0;
        mem_read_data = rdata_q;
        case (state)
            IDLE: begin
                if (issue) begin
                    stall      = 1'b1;
                    state_next = REQ;
                end else if (rd_only) begin
                    mem_read_data = cache_data;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus_err || bus_ack || expired) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            rdata_q     <= '0;
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_data  <= '0;
            err_flag    <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        bus_req   <= 1'b1;
                        bus_we    <= mem_wr;
                        bus_addr  <= mem_addr;
                        bus_wdata <= mem_write_data;
                        cnt       <= '0;
                    end
                end
                REQ: begin
                    cnt <= cnt + 8'd1;
                    if (bus_err) begin
                        bus_req  <= 1'b0;
                        rdata_q  <= '0;
                        err_flag <= 1'b1;
                    end else if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            rdata_q     <= bus_rdata;
                            cache_valid <= 1'b1;
                            cache_tag   <= bus_addr;
                            cache_data  <= bus_rdata;
                        end else if (cache_valid && (cache_tag == bus_addr)) begin
                            cache_data <= bus_wdata;
                        end
                    end else if (expired) begin
                        bus_req  <= 1'b0;
                        rdata_q  <= 32'hDEADBEEF;
                        err_flag <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: one instance with the default timeout for the
// cache/bus tests and one with TIMEOUT=4 for timeout and reset-abort tests.
module tb_dmem_bridge;

    logic        clk;
    logic        rst_a;
    logic        rst_b;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_wr;
    logic        mem_rd;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    logic [31:0] a_rdata, b_rdata;
    logic        a_stall, b_stall;
    logic        a_req, b_req;
    logic        a_we, b_we;
    logic [31:0] a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_err, b_err;

    logic        sel;
    logic [31:0] o_rdata;
    logic        o_stall;
    logic        o_req;
    logic        o_we;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic        o_err;

    int n_checks = 0;
    int n_errors = 0;

    dmem_bridge dut (
        .clk(clk), .reset(rst_a),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_read_data(a_rdata), .stall(a_stall),
        .bus_req(a_req), .bus_we(a_we), .bus_addr(a_addr), .bus_wdata(a_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
        .err_flag(a_err)
    );

    dmem_bridge #(.TIMEOUT(4)) dut_to (
        .clk(clk), .reset(rst_b),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_read_data(b_rdata), .stall(b_stall),
        .bus_req(b_req), .bus_we(b_we), .bus_addr(b_addr), .bus_wdata(b_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
        .err_flag(b_err)
    );

    assign o_rdata = sel ? b_rdata : a_rdata;
    assign o_stall = sel ? b_stall : a_stall;
    assign o_req   = sel ? b_req   : a_req;
    assign o_we    = sel ? b_we    : a_we;
    assign o_addr  = sel ? b_addr  : a_addr;
    assign o_wdata = sel ? b_wdata : a_wdata;
    assign o_err   = sel ? b_err   : a_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Holds the request until the DONE cycle, acking on REQ cycle delay+1.
    task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input int delay, input bit err,
                          input logic [31:0] rdata,
                          output int n_stall, output int n_req, output logic [31:0] data,
                          output logic we_seen, output logic [31:0] addr_seen,
                          output logic [31:0] wdata_seen);
        bit done = 0;
        bit ack_now;
        n_stall = 0; n_req = 0; data = '0;
        we_seen = 1'b0; addr_seen = '0; wdata_seen = '0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            mem_wr = wr; mem_rd = rd; mem_addr = addr; mem_write_data = wdata;
            if (o_req) begin
                if (n_req == 0) begin
                    we_seen = o_we; addr_seen = o_addr; wdata_seen = o_wdata;
                end
                n_req++;
            end
            ack_now   = o_req && (n_req == delay + 1);
            bus_ack   = ack_now;
            bus_err   = ack_now && err;
            bus_rdata = ack_now ? rdata : 32'h0;
            #1;
            if (o_stall) begin
                n_stall++;
            end else begin
                data = o_rdata;
                done = 1;
                break;
            end
        end
        if (!done) check("cycle_bound", 32'd0, 32'd1);
        @(negedge clk);
        mem_wr = 1'b0; mem_rd = 1'b0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
        #1;
    endtask

    int          ns, nr;
    logic [31:0] d, sa, sw;
    logic        swe;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0;
        mem_addr = '0; mem_write_data = '0; mem_wr = 1'b0; mem_rd = 1'b0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", 32'(o_req), 32'd0);
        check("rst_we", 32'(o_we), 32'd0);
        check("rst_addr", o_addr, 32'd0);
        check("rst_wdata", o_wdata, 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_stall_idle", 32'(o_stall), 32'd0);
        mem_rd = 1'b1; #1;
        check("rst_stall_rd", 32'(o_stall), 32'd1);
        mem_rd = 1'b0;
        @(negedge clk); rst_a = 1'b0;

        access(0, 1, 32'h100, 32'h0, 3, 0, 32'hCAFE0001, ns, nr, d, swe, sa, sw);
        check("miss_stall", 32'(ns), 32'd5);
        check("miss_req", 32'(nr), 32'd4);
        check("miss_data", d, 32'hCAFE0001);
        check("miss_we", 32'(swe), 32'd0);
        check("miss_addr", sa, 32'h100);
        check("no_reissue", 32'(o_req), 32'd0);

        access(0, 1, 32'h100, 32'h0, 0, 0, 32'h0, ns, nr, d, swe, sa, sw);
        check("hit_stall", 32'(ns), 32'd0);
        check("hit_req", 32'(nr), 32'd0);
        check("hit_data", d, 32'hCAFE0001);

        access(1, 0, 32'h100, 32'h12345678, 0, 0, 32'h0, ns, nr, d, swe, sa, sw);
        check("wr_stall", 32'(ns), 32'd2);
        check("wr_req", 32'(nr), 32'd1);
        check("wr_we", 32'(swe), 32'd1);
        check("wr_wdata", sw, 32'h12345678);
        access(0, 1, 32'h100, 32'h0, 0, 0, 32'h0, ns, nr, d, swe, sa, sw);
        check("wt_hit_stall", 32'(ns), 32'd0);
        check("wt_hit_req", 32'(nr), 32'd0);
        check("wt_hit_data", d, 32'h12345678);

        access(1, 0, 32'h200, 32'hAAAA5555, 0, 0, 32'h0, ns, nr, d, swe, sa, sw);
        check("wmiss_stall", 32'(ns), 32'd2);
        access(0, 1, 32'h200, 32'h0, 1, 0, 32'h0BADF00D, ns, nr, d, swe, sa, sw);
        check("noalloc_stall", 32'(ns), 32'd3);
        check("noalloc_req", 32'(nr), 32'd2);
        check("noalloc_data", d, 32'h0BADF00D);

        // ack and err together: err must win
        access(0, 1, 32'h300, 32'h0, 0, 1, 32'h11111111, ns, nr, d, swe, sa, sw);
        check("err_stall", 32'(ns), 32'd2);
        check("err_data", d, 32'h0);
        check("err_flag", 32'(o_err), 32'd1);
        access(0, 1, 32'h200, 32'h0, 0, 0, 32'h0, ns, nr, d, swe, sa, sw);
        check("err_cache_kept", d, 32'h0BADF00D);
        check("err_cache_kept_stall", 32'(ns), 32'd0);
        access(0, 1, 32'h300, 32'h0, 0, 0, 32'h33333333, ns, nr, d, swe, sa, sw);
        check("err_remiss_stall", 32'(ns), 32'd2);
        check("err_remiss_data", d, 32'h33333333);
        check("err_sticky", 32'(o_err), 32'd1);

        access(1, 1, 32'h300, 32'h55AA55AA, 0, 0, 32'h0, ns, nr, d, swe, sa, sw);
        check("wr_rd_we", 32'(swe), 32'd1);
        check("wr_rd_stall", 32'(ns), 32'd2);
        access(0, 1, 32'h300, 32'h0, 0, 0, 32'h0, ns, nr, d, swe, sa, sw);
        check("wr_rd_hit", d, 32'h55AA55AA);
        check("wr_rd_hit_stall", 32'(ns), 32'd0);

        rst_a = 1'b1;
        sel = 1'b1;
        @(negedge clk); rst_b = 1'b0; #1;
        check("to_rst_err", 32'(o_err), 32'd0);
        access(0, 1, 32'h400, 32'h0, 1000, 0, 32'h0, ns, nr, d, swe, sa, sw);
        check("to_stall", 32'(ns), 32'd5);
        check("to_req", 32'(nr), 32'd4);
        check("to_data", d, 32'hDEADBEEF);
        check("to_err", 32'(o_err), 32'd1);
        check("to_no_reissue", 32'(o_req), 32'd0);

        @(negedge clk);
        mem_rd = 1'b1; mem_addr = 32'h500; #1;
        check("abort_stall", 32'(o_stall), 32'd1);
        @(negedge clk); #1;
        check("abort_req_up", 32'(o_req), 32'd1);
        #2 rst_b = 1'b1; #1;
        check("abort_req_async", 32'(o_req), 32'd0);
        @(negedge clk);
        rst_b = 1'b0; mem_rd = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h77777777; #1;
        check("late_ack_req", 32'(o_req), 32'd0);
        check("late_ack_stall", 32'(o_stall), 32'd0);
        check("late_ack_err", 32'(o_err), 32'd0);
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = '0; #1;
        check("late_ack_rdata", o_rdata, 32'd0);
        access(0, 1, 32'h500, 32'h0, 0, 0, 32'h00000005, ns, nr, d, swe, sa, sw);
        check("abort_cache_invalid", 32'(ns), 32'd2);
        check("abort_reread_data", d, 32'h5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
